// File: rtl/snax_hwpe_periph_regs.sv
// Purpose: HWPE periph-port slave register file (trigger, status, done counter, job regs) with busy/done tracking.
// Latency: a granted access is performed at the grant edge; its response (r_valid/r_data/r_id) appears the next cycle.
// Backpressure: gnt_o follows req_i only while idle, so at most one access is accepted every two cycles.
module snax_hwpe_periph_regs #(
    parameter int NumRegs = 8,
    parameter int IdWidth = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [31:0]             add_i,
    input  logic                    wen_i,
    input  logic [3:0]              be_i,
    input  logic [31:0]             data_i,
    input  logic [IdWidth-1:0]      id_i,
    output logic                    r_valid_o,
    output logic [31:0]             r_data_o,
    output logic [IdWidth-1:0]      r_id_o,
    output logic                    start_o,
    output logic [32*NumRegs-1:0]   regs_o,
    output logic                    busy_o,
    input  logic                    done_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic [29:0] IdxTrigger = 30'd0;
    localparam logic [29:0] IdxStatus  = 30'd1;
    localparam logic [29:0] IdxDoneCnt = 30'd2;
    localparam logic [29:0] IdxJobBase = 30'd3;

    state_e              state_q, state_d;
    logic                busy_q;
    logic                err_q;
    logic [7:0]          cnt_q;
    logic                start_q;
    logic [31:0]         r_data_q;
    logic [IdWidth-1:0]  r_id_q;
    logic [31:0]         regs_q [NumRegs];

    logic [29:0]         widx;
    logic                acc;
    logic                wr;
    logic                hit_trig, hit_status, hit_cnt, hit_job;
    logic                trig_accept, trig_reject;
    logic                job_wr_ok, job_reject;
    logic                err_clr, cnt_clr, done_ok;
    logic [31:0]         rd_data;

    // Byte-offset bits never select anything; registers are word-granular.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^add_i[1:0];

    assign widx = add_i[31:2];

    // Handshake FSM: grant only while idle, then spend exactly one cycle responding.
    always_comb begin
        state_d   = state_q;
        gnt_o     = 1'b0;
        r_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                r_valid_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address decode, access side effects and read-data mux, all judged on pre-edge state.
    always_comb begin
        acc         = gnt_o;
        wr          = acc & ~wen_i;
        hit_trig    = (widx == IdxTrigger);
        hit_status  = (widx == IdxStatus);
        hit_cnt     = (widx == IdxDoneCnt);
        hit_job     = (widx >= IdxJobBase) && (widx < IdxJobBase + 30'(NumRegs));
        trig_accept = wr & hit_trig & be_i[0] & data_i[0] & ~busy_q;
        trig_reject = wr & hit_trig & be_i[0] & data_i[0] & busy_q;
        job_wr_ok   = wr & hit_job & ~busy_q;
        job_reject  = wr & hit_job & busy_q;
        err_clr     = wr & hit_status & be_i[0] & data_i[1];
        cnt_clr     = wr & hit_cnt & be_i[0];
        done_ok     = done_i & busy_q;
        rd_data     = 32'd0;
        if (hit_status) begin
            rd_data = {30'd0, err_q, busy_q};
        end else if (hit_cnt) begin
            rd_data = {24'd0, cnt_q};
        end else begin
            for (int k = 0; k < NumRegs; k++) begin
                if (widx == IdxJobBase + 30'(k)) begin
                    rd_data = regs_q[k];
                end
            end
        end
    end

    // Job tracking: busy, sticky error flag, completed-job counter and the start pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            start_q <= 1'b0;
        end else begin
            start_q <= trig_accept;
            if (trig_accept) begin
                busy_q <= 1'b1;
            end else if (done_ok) begin
                busy_q <= 1'b0;
            end
            if (trig_reject || job_reject) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            // A clear in the same cycle as a completion wins.
            if (cnt_clr) begin
                cnt_q <= 8'd0;
            end else if (done_ok) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Response capture: data and id hold until the next granted access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data_q <= 32'd0;
            r_id_q   <= '0;
        end else if (acc) begin
            r_id_q   <= id_i;
            r_data_q <= wen_i ? rd_data : 32'd0;
        end
    end

    // Byte-masked job register writes, blocked while a job runs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumRegs; k++) begin
                regs_q[k] <= 32'd0;
            end
        end else if (job_wr_ok) begin
            for (int k = 0; k < NumRegs; k++) begin
                if (widx == IdxJobBase + 30'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_i[b]) begin
                            regs_q[k][8*b +: 8] <= data_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NumRegs; g++) begin : g_regs_out
        assign regs_o[32*g +: 32] = regs_q[g];
    end

    assign r_data_o = r_data_q;
    assign r_id_o   = r_id_q;
    assign start_o  = start_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_snax_hwpe_periph_regs.sv
// Bench for snax_hwpe_periph_regs: transaction-level model checked every cycle plus literal checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The model advances once per rising edge from the bench's own stimulus.
module tb_snax_hwpe_periph_regs;

    localparam int NR = 8;
    localparam int IW = 5;
    localparam int VW = 32 * NR;

    logic           clk;
    logic           rst_n;
    logic           req;
    logic           gnt;
    logic [31:0]    add;
    logic           wen;
    logic [3:0]     be;
    logic [31:0]    wdata;
    logic [IW-1:0]  id;
    logic           r_valid;
    logic [31:0]    r_data;
    logic [IW-1:0]  r_id;
    logic           start;
    logic [VW-1:0]  regs;
    logic           busy;
    logic           done;

    snax_hwpe_periph_regs #(.NumRegs(NR), .IdWidth(IW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .gnt_o     (gnt),
        .add_i     (add),
        .wen_i     (wen),
        .be_i      (be),
        .data_i    (wdata),
        .id_i      (id),
        .r_valid_o (r_valid),
        .r_data_o  (r_data),
        .r_id_o    (r_id),
        .start_o   (start),
        .regs_o    (regs),
        .busy_o    (busy),
        .done_i    (done)
    );

    int nvec = 0;
    int nerr = 0;
    int nstart = 0;

    // Model state
    bit          m_busy, m_err, m_rvalid, m_start;
    int          m_cnt;
    logic [31:0] m_rdata;
    logic [IW-1:0] m_rid;
    logic [31:0] m_regs [NR];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [29:0] w);
        if (w == 30'd1) return {30'd0, m_err, m_busy};
        if (w == 30'd2) return 32'(m_cnt);
        if (w >= 30'd3 && w < 30'(3 + NR)) return m_regs[w - 30'd3];
        return 32'd0;
    endfunction

    function automatic logic [VW-1:0] model_regs();
        logic [VW-1:0] v;
        for (int k = 0; k < NR; k++) v[32*k +: 32] = m_regs[k];
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_rvalid = 0; m_start = 0; m_cnt = 0;
        m_rdata = 0; m_rid = 0;
        for (int k = 0; k < NR; k++) m_regs[k] = 0;
    endtask

    // Reference model: one accepted access at most per response slot, effects from the register rules.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                logic [29:0] w;
                bit g, pre_busy, cleared;
                w = add[31:2];
                g = req && !m_rvalid;
                pre_busy = m_busy;
                cleared = 0;
                m_start = 0;
                if (g) begin
                    m_rid = id;
                    m_rdata = wen ? model_read(w) : 32'd0;
                    if (!wen) begin
                        if (w == 30'd0) begin
                            if (be[0] && wdata[0]) begin
                                if (pre_busy) m_err = 1;
                                else begin m_busy = 1; m_start = 1; end
                            end
                        end else if (w == 30'd1) begin
                            if (be[0] && wdata[1]) m_err = 0;
                        end else if (w == 30'd2) begin
                            if (be[0]) begin m_cnt = 0; cleared = 1; end
                        end else if (w < 30'(3 + NR)) begin
                            if (pre_busy) m_err = 1;
                            else for (int b = 0; b < 4; b++)
                                if (be[b]) m_regs[w - 30'd3][8*b +: 8] = wdata[8*b +: 8];
                        end
                    end
                end
                m_rvalid = g;
                if (done && pre_busy) begin
                    m_busy = 0;
                    if (!cleared) m_cnt = (m_cnt + 1) % 256;
                end
            end
        end
    end

    // Every-cycle comparison against the model (or reset values while in reset).
    initial begin
        forever begin
            @(negedge clk);
            if (start) nstart++;
            if (!rst_n) begin
                chk("rst_gnt", VW'(gnt), 0);
                chk("rst_rvalid", VW'(r_valid), 0);
                chk("rst_rdata", VW'(r_data), 0);
                chk("rst_rid", VW'(r_id), 0);
                chk("rst_start", VW'(start), 0);
                chk("rst_busy", VW'(busy), 0);
                chk("rst_regs", regs, 0);
            end else begin
                chk("gnt", VW'(gnt), VW'(req && !m_rvalid));
                chk("r_valid", VW'(r_valid), VW'(m_rvalid));
                chk("r_data", VW'(r_data), VW'(m_rdata));
                chk("r_id", VW'(r_id), VW'(m_rid));
                chk("start", VW'(start), VW'(m_start));
                chk("busy", VW'(busy), VW'(m_busy));
                chk("regs", regs, model_regs());
            end
        end
    end

    // One access: request cycle, then response cycle; returns the sampled response.
    task automatic access(input logic w_en, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [IW-1:0] i, input logic dn,
                          output logic [31:0] rd, output logic [IW-1:0] rid);
        @(posedge clk); #1;
        req = 1; wen = w_en; add = a; be = b; wdata = d; id = i; done = dn;
        @(posedge clk); #1;
        req = 0; done = 0;
        @(negedge clk);
        rd = r_data; rid = r_id;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, input logic dn);
        logic [31:0] rd;
        logic [IW-1:0] rid;
        access(1'b0, a, b, d, 5'd1, dn, rd, rid);
        chk("wr_resp_data", VW'(rd), 0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic [IW-1:0] rid;
        access(1'b1, a, 4'hF, 32'd0, 5'd2, 1'b0, rd, rid);
        chk(name, VW'(rd), VW'(exp));
    endtask

    task automatic pulse_done();
        @(posedge clk); #1; done = 1;
        @(posedge clk); #1; done = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [IW-1:0] rid;
        int s0;
        rst_n = 0; req = 0; add = 0; wen = 1; be = 0; wdata = 0; id = 0; done = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Read STATUS after reset with id 3.
        @(posedge clk); #1;
        req = 1; wen = 1; add = 32'h4; be = 4'hF; id = 5'd3;
        @(negedge clk);
        chk("status_gnt_req_cycle", VW'(gnt), 1);
        @(posedge clk); #1; req = 0;
        @(negedge clk);
        chk("status_rvalid", VW'(r_valid), 1);
        chk("status_rdata", VW'(r_data), 0);
        chk("status_rid", VW'(r_id), 3);

        // Byte-masked job register 0 writes.
        wr(32'hC, 4'hF, 32'hA5A5A5A5, 0);
        wr(32'hC, 4'h1, 32'h000000FF, 0);
        rd_chk("job0_read", 32'hC, 32'hA5A5A5FF);
        chk("job0_regs_o", VW'(regs[31:0]), VW'(32'hA5A5A5FF));
        wr(32'h28, 4'b0110, 32'h11223344, 0);
        rd_chk("job7_read", 32'h28, 32'h00223300);
        wr(32'h2C, 4'hF, 32'hDEADBEEF, 0);
        rd_chk("oor_read", 32'h2C, 32'h0);

        // Trigger, rejected job write, completion.
        s0 = nstart;
        wr(32'h0, 4'h1, 32'h1, 0);
        chk("trig_busy", VW'(busy), 1);
        @(posedge clk);
        chk("trig_start_count", VW'(nstart - s0), 1);
        rd_chk("status_busy", 32'h4, 32'h1);
        wr(32'hC, 4'hF, 32'h12345678, 0);
        rd_chk("job0_unchanged", 32'hC, 32'hA5A5A5FF);
        rd_chk("status_busy_err", 32'h4, 32'h3);
        pulse_done();
        @(negedge clk);
        chk("done_busy", VW'(busy), 0);
        rd_chk("donecnt_1", 32'h8, 32'h1);
        wr(32'h4, 4'h1, 32'h2, 0);
        rd_chk("status_err_clr", 32'h4, 32'h0);

        // Trigger write while busy, in the same cycle as done.
        wr(32'h0, 4'h1, 32'h1, 0);
        s0 = nstart;
        wr(32'h0, 4'h1, 32'h1, 1);
        @(posedge clk);
        chk("trig_done_no_start", VW'(nstart - s0), 0);
        rd_chk("trig_done_status", 32'h4, 32'h2);
        rd_chk("trig_done_cnt", 32'h8, 32'h2);

        // Counter clear in the same cycle as done.
        wr(32'h0, 4'h1, 32'h1, 0);
        wr(32'h8, 4'h1, 32'h0, 1);
        chk("clr_done_busy", VW'(busy), 0);
        rd_chk("clr_done_cnt", 32'h8, 32'h0);

        // Wrap of the completed-job counter.
        for (int k = 0; k < 255; k++) begin
            wr(32'h0, 4'h1, 32'h1, 0);
            pulse_done();
        end
        rd_chk("cnt_255", 32'h8, 32'hFF);
        wr(32'h0, 4'h1, 32'h1, 0);
        pulse_done();
        rd_chk("cnt_wrap", 32'h8, 32'h0);
        wr(32'h4, 4'h1, 32'h2, 0);
        rd_chk("status_clr2", 32'h4, 32'h0);

        // Request held high for 3 cycles to an out-of-range address.
        @(posedge clk); #1;
        req = 1; wen = 1; add = 32'h100; be = 4'hF; id = 5'd7;
        @(negedge clk);
        chk("hold_gnt_c1", VW'(gnt), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_gnt_c2", VW'(gnt), 0);
        chk("hold_rvalid_c2", VW'(r_valid), 1);
        chk("hold_rdata_c2", VW'(r_data), 0);
        chk("hold_rid_c2", VW'(r_id), 7);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_gnt_c3", VW'(gnt), 1);
        chk("hold_rvalid_c3", VW'(r_valid), 0);
        @(posedge clk); #1; req = 0;
        @(negedge clk);

        // Reset during a pending response while busy.
        wr(32'h0, 4'h1, 32'h1, 0);
        @(posedge clk); #1;
        req = 1; wen = 1; add = 32'hC; id = 5'd9;
        @(posedge clk); #1;
        req = 0; rst_n = 0;
        #1;
        chk("midrst_rvalid", VW'(r_valid), 0);
        chk("midrst_busy", VW'(busy), 0);
        @(posedge clk); #1 rst_n = 1;
        rd_chk("midrst_status", 32'h4, 32'h0);
        rd_chk("midrst_job0", 32'hC, 32'h0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
